// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and register-file offsets used by the master
// bridge and anything that talks to the register-file slave.
package axi_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY    = 2'b00;
    localparam resp_t RESP_SLVERR  = 2'b10;
    localparam resp_t RESP_DECERR  = 2'b11;
    // A local abort is reported with the decode-error code.
    localparam resp_t RESP_TIMEOUT = RESP_DECERR;

    localparam logic [31:0] CTRL   = 32'h0000_0000;
    localparam logic [31:0] STATUS = 32'h0000_0004;
    localparam logic [31:0] DATA0  = 32'h0000_0008;
    localparam logic [31:0] DATA1  = 32'h0000_000C;

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Per-state handshake watchdog: counts cycles while enabled, flags expiry on
// the last allowed cycle. TIMEOUT_CYCLES=0 never expires.
module axi_lite_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (enable_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one cmd in, one AXI transaction out,
// one rsp back. A watchdog aborts any handshake that stalls too long.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output resp_t             rsp_resp,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  resp_t             bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  resp_t             rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    resp_t             rsp_resp_q, rsp_resp_d;

    logic tmo_busy, tmo_clear, tmo_expired, abort;

    assign tmo_busy  = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                       (state_q == S_RADDR) || (state_q == S_RDATA);
    assign tmo_clear = (state_d != state_q);

    axi_lite_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_busy),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        abort       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_WRITE: begin
                // AW and W retire independently; move on once neither is pending.
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    rsp_resp_d  = bresp;
                    rsp_rdata_d = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            S_RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Dropping bready/rready here is what makes a late slave response harmless.
        if (abort) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            bready_d    = 1'b0;
            rready_d    = 1'b0;
            rsp_resp_d  = RESP_TIMEOUT;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = S_RSP;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign arvalid   = arvalid_q;
    assign bready    = bready_q;
    assign rready    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite master bridge that converts a simple command/response interface into AXI4-Lite transactions.
- Sits directly upstream of the register-file slave (control/status/data_0/data_1 at 0x0/0x4/0x8/0xC). Used by the test sequencer and CPU-side glue to reach it.
- One transaction in flight at a time. Includes a handshake timeout so a hung slave cannot lock up the requester.

Parameters:
ADDR_W, 32, address width of cmd_addr and AXI addresses
DATA_W, 32, data width
TIMEOUT_CYCLES, 256, max cycles waiting on any single AXI handshake; 0 disables the timeout

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  AXI resp code; 2'b11 = timeout
awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  write address channel
wdata/wvalid/wready  out/out/in  DATA_W/1/1  write data channel
bresp/bvalid/bready  in/in/out  2/1/1  write response channel
araddr/arvalid/arready  out/out/in  ADDR_W/1/1  read address channel
rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  read data channel

Behaviour:
- Reset: state=IDLE. All valids, bready, rready and rsp_valid are 0. Addresses, wdata, rsp_rdata and rsp_resp are 0. Timeout counter is 0.
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RSP.
- cmd_ready = (state==IDLE); it is combinational from state only.
- IDLE, on a cmd handshake:
  - Latch addr/wdata.
  - Write: next cycle awvalid=wvalid=1, go WRITE.
  - Read: next cycle arvalid=1, go RADDR.
- WRITE:
  - awvalid drops the cycle after awvalid&&awready.
  - wvalid drops the cycle after wvalid&&wready, independently of awvalid.
  - Both may complete in the same or different cycles.
  - When both have completed: bready=1, go WRESP.
- WRESP: on bvalid&&bready, capture bresp into rsp_resp, set rsp_rdata=0, bready=0, rsp_valid=1, go RSP.
- RADDR: on arvalid&&arready, arvalid=0, rready=1, go RDATA.
- RDATA: on rvalid&&rready, capture rdata/rresp, rready=0, rsp_valid=1, go RSP.
- RSP: hold rsp_* stable until rsp_ready; then rsp_valid=0, go IDLE. Minimum idle-to-idle is therefore one bubble cycle.
- AXI valids, once asserted, are never withdrawn before their handshake, except on timeout.
- AXI address/data are stable while valid is high.
- Timeout:
  - The counter clears on every state change and increments each cycle in WRITE, WRESP, RADDR and RDATA.
  - When it reaches TIMEOUT_CYCLES-1 without completing: all AXI valid/ready outputs go to 0, rsp_resp=2'b11, rsp_rdata=0, go RSP.
  - A late slave response arriving after the abort is ignored (bready/rready are low).
  - TIMEOUT_CYCLES=0 means never time out.
- Latency, zero-wait slave, write: cmd handshake cycle N → awvalid/wvalid at N+1 → bready at N+2 → rsp_valid no earlier than N+3.
- Latency with the register-file slave: its ready lags valid by one cycle, so rsp_valid follows accordingly. The bench must not hardcode the total.
- Reset mid-operation: all outputs return to reset values immediately (async). Any pending response is discarded.
- Response codes pass through unmodified (00 OKAY, 10 SLVERR).

Decomposition:
- Shared package axi_lite_pkg:
  - typedef resp_t (logic [1:0]).
  - Constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, RESP_TIMEOUT=RESP_DECERR.
  - Register offsets CTRL=0x0, STATUS=0x4, DATA0=0x8, DATA1=0xC.
- The master state enum is local to the module.
- One natural sub-module: axi_lite_timeout_ctr (clear, enable, expired), parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write 0x8 data 0xDEADBEEF, then read 0x8 against the register-file slave → write rsp_resp=00; read rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Read 0x10 → rsp_resp=10, rsp_rdata=0. Write 0x14 data 0x1 → rsp_resp=10, and no register changes (0x0–0xC read back unchanged).
- Behavioural slave with awready at cycle+1 and wready at cycle+4 → awvalid drops first, wvalid held with stable wdata until its handshake. Exactly one bready pulse; rsp_resp=00.
- Hold rsp_ready=0 for 10 cycles after a read of 0x4 → rsp_valid and rsp_rdata stay stable, cmd_ready=0 throughout, and no new AXI valids appear.
- TIMEOUT_CYCLES=16 with a slave that never raises arready → arvalid drops after 16 cycles in RADDR, rsp_resp=11. A following write to 0x0 completes normally.
- Assert aresetn=0 during WRESP → all valids/readies and rsp_valid are 0 immediately. After release, cmd_ready=1 and a read of 0x0 succeeds.
